// File: rtl/ram_dp_be.sv
// Simple-dual-port data RAM with byte-enable writes, a pipelined read port, a hardware clear
// engine and write-first bypass. Define RAM_PARITY_EN to add per-byte even parity.
module ram_dp_be #(
    parameter int DW         = 16,
    parameter int AW         = 8,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    output logic            o_busy,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [DW/8-1:0] i_wr_be,
`ifdef RAM_PARITY_EN
    input  logic [DW/8-1:0] i_wr_par_inv,
    output logic [DW/8-1:0] o_rd_perr,
`endif
    input  logic            i_rd_en,
    input  logic [AW-1:0]   i_rd_addr,
    output logic [DW-1:0]   o_rd_data,
    output logic            o_rd_valid
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_next;
    logic [AW:0]     w_cnt_inc;
    logic            w_clr_last;

    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_idle;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_same_addr;

    logic            r_v1;
    logic [DW-1:0]   r_q1;
    logic [NB-1:0]   r_byp_be;
    logic [DW-1:0]   r_byp_data;
    logic [DW-1:0]   w_s1_data;

`ifdef RAM_PARITY_EN
    logic [NB-1:0]   r_par [DEPTH];
    logic [NB-1:0]   w_wr_par;
    logic [NB-1:0]   r_qp1;
    logic [NB-1:0]   r_byp_par;
    logic [NB-1:0]   w_s1_par;
    logic [NB-1:0]   w_s1_perr;
`endif

    assign w_idle      = (r_state == ST_IDLE);
    assign w_wr_acc    = w_idle & i_wr_en;
    assign w_rd_acc    = w_idle & i_rd_en;
    assign w_same_addr = w_wr_acc & (i_wr_addr == i_rd_addr);
    assign o_busy      = (r_state == ST_CLEAR);

    // The extra counter bit flags the wrap past the last address.
    assign w_cnt_inc  = r_cnt + (AW+1)'(1);
    assign w_clr_last = w_cnt_inc[AW];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_cnt_next = w_cnt_inc;
                if (w_clr_last) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Storage has no reset; the clear engine is the only way to zero it.
    always_ff @(posedge i_clk) begin
        if (!w_idle) begin
            r_mem[r_cnt[AW-1:0]] <= '0;
`ifdef RAM_PARITY_EN
            r_par[r_cnt[AW-1:0]] <= '0;
`endif
        end else if (w_wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (i_wr_be[i]) begin
                    r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
`ifdef RAM_PARITY_EN
                    r_par[i_wr_addr][i] <= w_wr_par[i];
`endif
                end
            end
        end
    end

    // First read stage: registered array read plus the lanes a same-address write overrides.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1       <= 1'b0;
            r_q1       <= '0;
            r_byp_be   <= '0;
            r_byp_data <= '0;
`ifdef RAM_PARITY_EN
            r_qp1      <= '0;
            r_byp_par  <= '0;
`endif
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_q1       <= r_mem[i_rd_addr];
                r_byp_be   <= i_wr_be & {NB{w_same_addr}};
                r_byp_data <= i_wr_data;
`ifdef RAM_PARITY_EN
                r_qp1      <= r_par[i_rd_addr];
                r_byp_par  <= w_wr_par;
`endif
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_s1_data[8*gi +: 8] = r_byp_be[gi] ? r_byp_data[8*gi +: 8]
                                                       : r_q1[8*gi +: 8];
`ifdef RAM_PARITY_EN
            assign w_wr_par[gi]  = (^i_wr_data[8*gi +: 8]) ^ i_wr_par_inv[gi];
            assign w_s1_par[gi]  = r_byp_be[gi] ? r_byp_par[gi] : r_qp1[gi];
            assign w_s1_perr[gi] = (^w_s1_data[8*gi +: 8]) ^ w_s1_par[gi];
`endif
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] r_out;
            logic          r_v2;
`ifdef RAM_PARITY_EN
            logic [NB-1:0] r_perr2;
`endif
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_out   <= '0;
                    r_v2    <= 1'b0;
`ifdef RAM_PARITY_EN
                    r_perr2 <= '0;
`endif
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_out   <= w_s1_data;
`ifdef RAM_PARITY_EN
                        r_perr2 <= w_s1_perr;
`endif
                    end
                end
            end
            assign o_rd_data  = r_out;
            assign o_rd_valid = r_v2;
`ifdef RAM_PARITY_EN
            assign o_rd_perr  = r_perr2;
`endif
        end else begin : g_lat1
            // Stage-1 registers only load on an accepted read, so the data holds between reads.
            assign o_rd_data  = w_s1_data;
            assign o_rd_valid = r_v1;
`ifdef RAM_PARITY_EN
            assign o_rd_perr  = w_s1_perr;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: one instance at read latency 1 and one at latency 2 share stimulus.
module tb_ram_dp_be;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NB = DW / 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clr     = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be   = '0;
    logic          busy1, busy2, v1, v2;
    logic [DW-1:0] d1, d2;
`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_inv = '0;
    logic [NB-1:0] perr1, perr2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_dp_be #(.DW(DW), .AW(AW), .RD_LAT(1), .CLR_ON_RST(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_busy(busy1),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
`ifdef RAM_PARITY_EN
        .i_wr_par_inv(par_inv), .o_rd_perr(perr1),
`endif
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(d1), .o_rd_valid(v1)
    );

    ram_dp_be #(.DW(DW), .AW(AW), .RD_LAT(2), .CLR_ON_RST(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_busy(busy2),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
`ifdef RAM_PARITY_EN
        .i_wr_par_inv(par_inv), .o_rd_perr(perr2),
`endif
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(d2), .o_rd_valid(v2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_be = '0;
        $display("wr addr=%0d data=%h be=%b", a, d, be);
    endtask

    // Checks the latency-1 result after one edge and the latency-2 result after the next.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check_val({tag, "_v1"}, 32'(v1), 32'd1);
        check_val({tag, "_d1"}, 32'(d1), 32'(exp));
        check_val({tag, "_v2early"}, 32'(v2), 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_v2"}, 32'(v2), 32'd1);
        check_val({tag, "_d2"}, 32'(d2), 32'(exp));
        check_val({tag, "_v1off"}, 32'(v1), 32'd0);
        check_val({tag, "_d1hold"}, 32'(d1), 32'(exp));
        $display("rd addr=%0d data1=%h data2=%h", a, d1, d2);
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, 32'(n), 32'd16);
        $display("clear %s busy_cycles=%0d", tag, n);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy1", 32'(busy1), 32'd1);
        check_val("rst_busy2", 32'(busy2), 32'd1);
        check_val("rst_v1", 32'(v1), 32'd0);
        check_val("rst_v2", 32'(v2), 32'd0);
        check_val("rst_d1", 32'(d1), 32'd0);
        check_val("rst_d2", 32'(d2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("init_clear");
        for (int a = 0; a < 16; a++) do_read(AW'(a), 16'h0000, "init_zero");

        // Byte-enable merge
        do_write(4'd5, 16'hA55A, 2'b11);
        do_write(4'd5, 16'h00FF, 2'b01);
        do_read(4'd5, 16'hA5FF, "be_merge");
        do_write(4'd5, 16'hFFFF, 2'b00);
        do_read(4'd5, 16'hA5FF, "be_none");

        // Write-first bypass on the same address
        do_write(4'd3, 16'hABCD, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; wr_be = 2'b10;
        do_read(4'd3, 16'h12CD, "bypass");
        wr_en = 1'b0; wr_be = '0;
        do_read(4'd3, 16'h12CD, "bypass_stored");

        // Different addresses in the same cycle
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h5678; wr_be = 2'b11;
        do_read(4'd5, 16'hA5FF, "indep_rd");
        wr_en = 1'b0; wr_be = '0;
        do_read(4'd8, 16'h5678, "indep_wr");

        // Back-to-back reads
        do_write(4'd1, 16'h1111, 2'b11);
        do_write(4'd2, 16'h2222, 2'b11);
        do_write(4'd3, 16'h3333, 2'b11);
        rd_en = 1'b1; rd_addr = 4'd1;
        @(posedge clk); #1;
        check_val("b2b_p1_v1", 32'(v1), 32'd1);
        check_val("b2b_p1_d1", 32'(d1), 32'h1111);
        check_val("b2b_p1_v2", 32'(v2), 32'd0);
        rd_addr = 4'd2;
        @(posedge clk); #1;
        check_val("b2b_p2_d1", 32'(d1), 32'h2222);
        check_val("b2b_p2_v2", 32'(v2), 32'd1);
        check_val("b2b_p2_d2", 32'(d2), 32'h1111);
        rd_addr = 4'd3;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check_val("b2b_p3_d1", 32'(d1), 32'h3333);
        check_val("b2b_p3_v2", 32'(v2), 32'd1);
        check_val("b2b_p3_d2", 32'(d2), 32'h2222);
        @(posedge clk); #1;
        check_val("b2b_p4_v1", 32'(v1), 32'd0);
        check_val("b2b_p4_v2", 32'(v2), 32'd1);
        check_val("b2b_p4_d2", 32'(d2), 32'h3333);
        @(posedge clk); #1;
        check_val("b2b_p5_v2", 32'(v2), 32'd0);
        check_val("b2b_p5_d2hold", 32'(d2), 32'h3333);
        $display("b2b reads 1,2,3 done");

        // Clear request with a read issued in the same cycle and accesses held while busy
        clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
        @(posedge clk); #1;
        clr = 1'b0;
        check_val("clr_busy", 32'(busy1), 32'd1);
        check_val("clr_inflight_v1", 32'(v1), 32'd1);
        check_val("clr_inflight_d1", 32'(d1), 32'hA5FF);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_addr = 4'd8;
        @(posedge clk); #1;
        check_val("clr_inflight_v2", 32'(v2), 32'd1);
        check_val("clr_inflight_d2", 32'(d2), 32'hA5FF);
        check_val("clr_drop_v1", 32'(v1), 32'd0);
        n = 1;
        while (busy1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            check_val("clr_drop_v1", 32'(v1), 32'd0);
            check_val("clr_drop_v2", 32'(v2), 32'd0);
        end
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
        check_val("clr_busy_len", 32'(n), 32'd16);
        $display("clear request busy_cycles=%0d", n);
        for (int a = 0; a < 16; a++) do_read(AW'(a), 16'h0000, "post_clr");

        // Reset in the middle of a clear restarts it from address 0
        do_write(4'd2, 16'hBEEF, 2'b11);
        do_write(4'd12, 16'hBEEF, 2'b11);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy1), 32'd1);
        check_val("midrst_v1", 32'(v1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("restart_clear");
        do_read(4'd12, 16'h0000, "restart_hi");
        do_read(4'd2, 16'h0000, "restart_lo");

`ifdef RAM_PARITY_EN
        // Parity fault injection on lane 0 and a clean write for contrast
        par_inv = 2'b01;
        do_write(4'd7, 16'h0101, 2'b11);
        par_inv = 2'b00;
        do_write(4'd8, 16'h0301, 2'b11);
        rd_en = 1'b1; rd_addr = 4'd7;
        @(posedge clk); #1;
        rd_addr = 4'd8;
        check_val("par_d1", 32'(d1), 32'h0101);
        check_val("par_perr1", 32'(perr1), 32'(2'b01));
        @(posedge clk); #1;
        rd_en = 1'b0;
        check_val("par_perr2", 32'(perr2), 32'(2'b01));
        check_val("par_clean_perr1", 32'(perr1), 32'(2'b00));
        @(posedge clk); #1;
        check_val("par_clean_perr2", 32'(perr2), 32'(2'b00));
        $display("parity reads 7,8 done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
